// File: rtl/arb_mux.sv
// Registered N-channel multiplexer with per-channel valid/ready handshakes.
// A channel is picked by an explicit select or by round-robin arbitration.
module arb_mux #(
    parameter  int WIDTH    = 32,
    parameter  int CHANNELS = 4,
    localparam int SEL_W    = (CHANNELS <= 2) ? 1 : $clog2(CHANNELS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        mode,
    input  logic [SEL_W-1:0]            sel,
    input  logic [CHANNELS*WIDTH-1:0]   in_data,
    input  logic [CHANNELS-1:0]         in_valid,
    output logic [CHANNELS-1:0]         in_ready,
    output logic [WIDTH-1:0]            out_data,
    output logic [SEL_W-1:0]            out_chan,
    output logic                        out_valid,
    input  logic                        out_ready
);

    logic [WIDTH-1:0] r_out_data;
    logic [SEL_W-1:0] r_out_chan;
    logic             r_out_valid;
    logic [SEL_W-1:0] r_rr_ptr;

    logic             w_can_load;
    logic             w_sel_ok;
    logic             w_rr_found;
    logic [SEL_W-1:0] w_rr_grant;
    logic [SEL_W-1:0] w_grant;
    logic             w_have_grant;
    logic             w_xfer;
    logic [SEL_W-1:0] w_rr_next;

    assign w_can_load = !r_out_valid || out_ready;
    assign w_sel_ok   = int'(sel) < CHANNELS;

    // Round-robin search: first valid channel at or after r_rr_ptr, wrapping.
    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, otherwise synthesis infers a latch.
    always_comb begin
        w_rr_found = 1'b0;
        w_rr_grant = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            int idx;
            idx = int'(r_rr_ptr) + k;
            if (idx >= CHANNELS) idx = idx - CHANNELS;
            if (!w_rr_found && in_valid[idx]) begin
                w_rr_found = 1'b1;
                w_rr_grant = SEL_W'(idx);
            end
        end
    end

    assign w_grant      = mode ? w_rr_grant : sel;
    assign w_have_grant = mode ? w_rr_found : w_sel_ok;
    assign w_xfer       = w_have_grant && w_can_load && in_valid[w_grant];
    assign w_rr_next    = (int'(w_grant) == CHANNELS - 1) ? '0 : w_grant + 1'b1;

    always_comb begin
        in_ready = '0;
        if (w_have_grant && w_can_load) in_ready[w_grant] = 1'b1;
    end

    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_data  <= '0;
            r_out_chan  <= '0;
            r_out_valid <= 1'b0;
            r_rr_ptr    <= '0;
        end else if (w_xfer) begin
            r_out_data  <= in_data[int'(w_grant)*WIDTH +: WIDTH];
            r_out_chan  <= w_grant;
            r_out_valid <= 1'b1;
            if (mode) r_rr_ptr <= w_rr_next;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_data  = r_out_data;
    assign out_chan  = r_out_chan;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_arb_mux.sv
// Self-checking bench for arb_mux: directed scenarios plus randomized traffic
// compared against a rule-level reference model.
module tb_arb_mux;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;

    // 4-channel instance
    logic          mode = 1'b0;
    logic [1:0]    sel = '0;
    logic [127:0]  in_data = '0;
    logic [3:0]    in_valid = '0;
    logic [3:0]    in_ready;
    logic [31:0]   out_data;
    logic [1:0]    out_chan;
    logic          out_valid;
    logic          out_ready = 1'b1;

    // 3-channel instance
    logic          mode3 = 1'b0;
    logic [1:0]    sel3 = '0;
    logic [95:0]   in_data3 = '0;
    logic [2:0]    in_valid3 = '0;
    logic [2:0]    in_ready3;
    logic [31:0]   out_data3;
    logic [1:0]    out_chan3;
    logic          out_valid3;
    logic          out_ready3 = 1'b1;

    int n_cmp = 0;
    int n_fail = 0;

    logic [31:0] ch_data [4];

    // Reference model state
    logic        m_valid;
    logic [31:0] m_data;
    int          m_chan;
    int          m_ptr;

    arb_mux #(.WIDTH(W), .CHANNELS(4)) dut (
        .clk(clk), .rst(rst), .mode(mode), .sel(sel),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_chan(out_chan), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    arb_mux #(.WIDTH(W), .CHANNELS(3)) dut3 (
        .clk(clk), .rst(rst), .mode(mode3), .sel(sel3),
        .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
        .out_data(out_data3), .out_chan(out_chan3), .out_valid(out_valid3),
        .out_ready(out_ready3)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] model_ready();
        if (m_valid && !out_ready) return 4'b0000;
        if (!mode) return (int'(sel) < 4) ? (4'b0001 << sel) : 4'b0000;
        for (int k = 0; k < 4; k++) begin
            int idx;
            idx = (m_ptr + k) % 4;
            if (in_valid[idx]) return 4'b0001 << idx;
        end
        return 4'b0000;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = '0;
        m_chan  = 0;
        m_ptr   = 0;
    endtask

    task automatic randomize_data();
        for (int i = 0; i < 4; i++) ch_data[i] = $urandom;
    endtask

    // One cycle: drive at the falling edge, check in_ready mid-cycle, then
    // advance the model at the rising edge and check the registered outputs.
    task automatic step(input logic m, input logic [1:0] s, input logic [3:0] v, input logic ordy);
        logic [3:0] exp_rdy;
        logic [3:0] xfer;
        @(negedge clk);
        mode = m; sel = s; in_valid = v; out_ready = ordy;
        for (int i = 0; i < 4; i++) in_data[i*W +: W] = ch_data[i];
        #1;
        exp_rdy = model_ready();
        check("in_ready", 64'(in_ready), 64'(exp_rdy));
        @(posedge clk);
        xfer = exp_rdy & v;
        if (xfer != 4'b0000) begin
            int g;
            g = 0;
            for (int i = 0; i < 4; i++) if (xfer[i]) g = i;
            m_valid = 1'b1;
            m_data  = ch_data[g];
            m_chan  = g;
            if (m) m_ptr = (g + 1) % 4;
        end else if (ordy) begin
            m_valid = 1'b0;
        end
        #1;
        check("out_valid", 64'(out_valid), 64'(m_valid));
        check("out_data", 64'(out_data), 64'(m_data));
        check("out_chan", 64'(out_chan), 64'(m_chan));
    endtask

    initial begin
        model_reset();
        randomize_data();

        // Reset state
        #1;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_data", 64'(out_data), 64'(0));
        check("rst_out_chan", 64'(out_chan), 64'(0));
        @(negedge clk);
        rst = 1'b1;

        // Explicit select of channel 2
        ch_data[2] = 32'h0000_0022;
        step(1'b0, 2'd2, 4'b1111, 1'b1);
        check("sel2_chan", 64'(out_chan), 64'(2));
        check("sel2_data", 64'(out_data), 64'h22);

        // Round robin, all valid, 8 cycles without bubbles
        for (int k = 0; k < 8; k++) begin
            randomize_data();
            step(1'b1, 2'd0, 4'b1111, 1'b1);
            check("rr_seq_chan", 64'(out_chan), 64'(k % 4));
        end

        // Move pointer to 2 via ch1, then only ch1/ch3 valid: 3,1,3
        randomize_data();
        step(1'b1, 2'd0, 4'b0010, 1'b1);
        randomize_data();
        step(1'b1, 2'd0, 4'b1010, 1'b1);
        check("sparse_first", 64'(out_chan), 64'(3));
        randomize_data();
        step(1'b1, 2'd0, 4'b1010, 1'b1);
        check("sparse_second", 64'(out_chan), 64'(1));
        randomize_data();
        step(1'b1, 2'd0, 4'b1010, 1'b1);
        check("sparse_third", 64'(out_chan), 64'(3));

        // Backpressure: hold for 3 cycles, then load on release
        for (int k = 0; k < 3; k++) begin
            randomize_data();
            step(1'b1, 2'd0, 4'b1111, 1'b0);
            check("stall_chan", 64'(out_chan), 64'(3));
        end
        randomize_data();
        step(1'b1, 2'd0, 4'b1111, 1'b1);
        check("unstall_chan", 64'(out_chan), 64'(0));

        // Asynchronous reset in the middle of a stall
        ch_data[0] = 32'hDEAD_BEEF;
        step(1'b0, 2'd0, 4'b0001, 1'b1);
        step(1'b0, 2'd0, 4'b0000, 1'b0);
        check("pre_rst_data", 64'(out_data), 64'hDEAD_BEEF);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check("midrst_out_valid", 64'(out_valid), 64'(0));
        check("midrst_out_data", 64'(out_data), 64'(0));
        check("midrst_out_chan", 64'(out_chan), 64'(0));
        @(negedge clk);
        rst = 1'b1;
        randomize_data();
        step(1'b1, 2'd0, 4'b1111, 1'b1);
        check("post_rst_first", 64'(out_chan), 64'(0));

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            randomize_data();
            step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 4'($urandom), ($urandom_range(0, 3) != 0));
        end

        // Three channels: out-of-range select, then round robin
        @(negedge clk);
        mode3 = 1'b0; sel3 = 2'd3; in_valid3 = 3'b111;
        in_data3 = {32'h0000_0C02, 32'h0000_0C01, 32'h0000_0C00};
        #1;
        check("c3_sel3_ready", 64'(in_ready3), 64'(0));
        @(posedge clk);
        #1;
        check("c3_sel3_valid", 64'(out_valid3), 64'(0));
        @(negedge clk);
        mode3 = 1'b1;
        #1;
        check("c3_rr_ready", 64'(in_ready3), 64'(3'b001));
        @(posedge clk);
        #1;
        check("c3_rr_valid", 64'(out_valid3), 64'(1));
        check("c3_rr_chan", 64'(out_chan3), 64'(0));
        check("c3_rr_data", 64'(out_data3), 64'h0C00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
